mem_port_master: RTL
====================

// Module: mem_port_master
// PURPOSE
//  Initiator side of the word-addressed data Memory port (ren/wen/addr/din/dout).
//  Accepts one load/store request at a time from the MIPS datapath and drives the memory handshake.
//  Handles byte, halfword and word accesses: lane extraction with sign/zero extension on loads,
//  and read-modify-write for sub-word stores. Rejects misaligned and out-of-range requests without touching memory.
// PARAMETERS
//  WORD_ADDR_BITS  10  number of word-index bits the memory decodes; mem_addr bits above this are always 0
// PORTS
//  clock       in   1   single clock; all state updates on posedge
//  reset       in   1   synchronous, active-high; sampled on posedge clock
//  req_valid   in   1   request present; taken when req_valid & req_ready at posedge
//  req_ready   out  1   high only in IDLE
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   2   `SIZE_B / `SIZE_H / `SIZE_W (00/01/10); 11 is treated as misaligned
//  req_signed  in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified for B/H
//  resp_valid  out  1   one-cycle completion pulse, for loads and stores
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: misaligned, bad size, or address beyond memory range
//  mem_ren     out  1   to Memory ren
//  mem_wen     out  1   to Memory wen
//  mem_addr    out  32  word index = req_addr[WORD_ADDR_BITS+1:2], upper bits zero
//  mem_din     out  32  to Memory din
//  mem_dout    in   32  from Memory dout; combinational when ren=1 and wen=0
// BEHAVIOUR
//  - All outputs are registered. Reset values: state IDLE, mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0,
//    resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
//  - States: IDLE, RD, RMW_RD, RMW_MRG, WR, RESP.
//  - Request accept cycle t, by request type:
//      error -> RESP@t+1
//      load -> RD@t+1 -> RESP@t+2
//      word store -> WR@t+1 -> RESP@t+2
//      B/H store -> RMW_RD@t+1 -> RMW_MRG@t+2 -> WR@t+3 -> RESP@t+4
//  - After RESP, the next state is IDLE.
//  - Errors are: H with addr[0]=1; W with addr[1:0]!=0; size 11; req_addr[31:WORD_ADDR_BITS+2]!=0.
//    Error requests produce no ren/wen activity.
//  - mem_ren=1 in RD and RMW_RD only. mem_wen=1 in WR only.
//  - ren and wen are never high together. At least one cycle has both low between an RMW read and its write (RMW_MRG).
//  - mem_dout is captured at the posedge that ends RD or RMW_RD.
//  - In RMW_MRG, the byte or halfword is merged into the captured word.
//  - mem_addr is loaded at accept and held constant until the next accept. mem_din is valid throughout WR.
//  - Lanes are little-endian: byte k = bits [8k+7:8k]; half at addr[1] selects bits [15:0] or [31:16].
//  - Memory commits the write at the negedge inside WR. The memory's reset pin must be tied high at integration.
//  - req_valid while busy is ignored (not queued). The requester holds it until req_ready.
//  - Reset mid-operation: the next state is IDLE and all outputs return to reset values.
//    A WR cycle already in progress still commits at its negedge, since wen was high for that cycle.
//    An RMW aborted before WR writes nothing, and no resp_valid is produced for aborted requests.
// STRUCTURE
//  - constants.h: `SIZE_B/`SIZE_H/`SIZE_W and state encodings (3-bit).
//  - Sub-module mem_lane_align (combinational):
//      extract(word, addr[1:0], size, signed) -> rdata
//      merge(word, wdata, addr[1:0], size) -> word
//  - The top level holds the FSM, the request latch and the output registers.
// TESTING
//  - Word store then load: st W 0x0000_0010 <- 0xDEADBEEF.
//      Response: wen=1 one cycle, mem_addr=4, resp@t+2.
//      Then ld W 0x10 returns rdata=0xDEADBEEF, err=0, resp@t+2.
//  - Sub-word loads, with mem word 4 = 0x80FF_7F01:
//      lb 0x12 -> 0xFFFFFFFF (signed), lbu 0x13 -> 0x00000080
//      lh 0x10 -> 0x00007F01, lh 0x12 -> 0xFFFF80FF
//  - Byte RMW: word 4 = 0x11223344; sb 0x11 <- 0xAA.
//      Response: ren, one cycle with ren=wen=0, wen, with mem_din=0x1122AA44, resp@t+4.
//      Readback of 0x10 returns 0x1122AA44.
//  - Errors: lw 0x0000_0002, sh 0x0000_0005, size=11, and ld 0x0000_1000 (WORD_ADDR_BITS=10).
//      Each gives resp_err=1 at t+1 with no ren/wen pulse.
//  - Back-to-back requests with req_valid held high:
//      req_ready is low in RD/WR/RESP.
//      The second request is accepted in the first IDLE cycle.
//      Assert ren&wen is never 1 in any cycle.
//  - Reset during RMW_MRG of sb 0x11: the word in memory is unchanged, resp_valid stays 0, and outputs equal reset values next cycle.
//      Reset during WR: the write lands, and there is no resp.

Source files
------------

// File: rtl/mem_port_master_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states, alignment check.
package mem_port_master_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RMW_RD  = 3'd2,
    ST_RMW_MRG = 3'd3,
    ST_WR      = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // Size 11 has no legal alignment, so it is folded into the misaligned case.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_H) && lo[0]) ||
           ((size == SIZE_W) && (lo != 2'b00)) ||
           (size == SIZE_BAD);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: load extraction with sign/zero extension and sub-word store merge.
// Purely combinational; no latency and no flow control.
module mem_lane_align
  import mem_port_master_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rd_word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    rdata  = rd_word;
    case (size)
      SIZE_B:  rdata = {{24{sgn & byte_v[7]}}, byte_v};
      SIZE_H:  rdata = {{16{sgn & half_v[15]}}, half_v};
      default: rdata = rd_word;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SIZE_B: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SIZE_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_master.sv
// Single-outstanding load/store initiator for the word-addressed data memory; loads and word stores
// respond 2 cycles after accept, sub-word stores 4 (read-modify-write), errors 1; req_ready only in IDLE.
module mem_port_master
  import mem_port_master_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  state_t state, state_nxt;

  logic        accept;
  logic        req_err;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] ext_rdata;
  logic [31:0] merged;

  assign accept  = req_valid & req_ready;
  assign req_err = misaligned(req_size, req_addr[1:0]) ||
                   (req_addr[31:WORD_ADDR_BITS+2] != '0);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                 state_nxt = ST_RESP;
          else if (!req_we)            state_nxt = ST_RD;
          else if (req_size == SIZE_W) state_nxt = ST_WR;
          else                         state_nxt = ST_RMW_RD;
        end
      end
      ST_RD:      state_nxt = ST_RESP;
      ST_RMW_RD:  state_nxt = ST_RMW_MRG;
      ST_RMW_MRG: state_nxt = ST_WR;
      ST_WR:      state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  mem_lane_align u_align (
    .rd_word  (mem_dout),
    .old_word (word_q),
    .wdata    (wdata_q),
    .addr_lo  (lo_q),
    .size     (size_q),
    .sgn      (signed_q),
    .rdata    (ext_rdata),
    .merged   (merged)
  );

  // Strobes are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready  <= 1'b1;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      size_q     <= SIZE_B;
      signed_q   <= 1'b0;
      lo_q       <= 2'b00;
      wdata_q    <= '0;
      word_q     <= '0;
    end else begin
      req_ready  <= (state_nxt == ST_IDLE);
      mem_ren    <= (state_nxt == ST_RD) || (state_nxt == ST_RMW_RD);
      mem_wen    <= (state_nxt == ST_WR);
      resp_valid <= (state_nxt == ST_RESP);
      resp_err   <= (state == ST_IDLE) && accept && req_err;
      resp_rdata <= (state == ST_RD) ? ext_rdata : '0;

      if (accept) begin
        mem_addr <= {{(32-WORD_ADDR_BITS){1'b0}}, req_addr[WORD_ADDR_BITS+1:2]};
        size_q   <= req_size;
        signed_q <= req_signed;
        lo_q     <= req_addr[1:0];
        wdata_q  <= req_wdata;
        if (req_we && (req_size == SIZE_W) && !req_err) mem_din <= req_wdata;
      end

      if (state == ST_RMW_RD)  word_q  <= mem_dout;
      if (state == ST_RMW_MRG) mem_din <= merged;
    end
  end

endmodule
